// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter types and constants for the KANADE32 memory-port arbiter and future bus arbiters.
// Holds only declarations: no latency or backpressure of its own.
package kanade_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   // Index width that stays legal for a single-channel build.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wait counter only ever holds WAIT_CYCLES-1 down to 0.
   function automatic int cnt_w(input int wait_cycles);
      return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side request/done bundle plus the RAM-side port of the shared memory arbiter.
// slave = arbiter view, master = requesters and RAM (testbench) view.
interface mem_port_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        we;
   logic [NUM_CH*ADDR_W-1:0] addr;
   logic [NUM_CH*DATA_W-1:0] wdata;
   logic [NUM_CH-1:0]        gnt;
   logic [NUM_CH-1:0]        done;
   logic [DATA_W-1:0]        rdata;
   logic [ADDR_W-3:0]        ram_addr;
   logic [DATA_W-1:0]        ram_wdata;
   logic                     ram_wren;
   logic [DATA_W-1:0]        ram_q;

   modport slave (
      input  req, we, addr, wdata, ram_q,
      output gnt, done, rdata, ram_addr, ram_wdata, ram_wren
   );

   modport master (
      output req, we, addr, wdata, ram_q,
      input  gnt, done, rdata, ram_addr, ram_wdata, ram_wren
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: fixed (lowest index) or round-robin after last_grant.
// Zero latency; no backpressure, winner is only meaningful while some req bit is set.
module mem_arb_pick
   import kanade_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  last_grant,
   input  logic              mode,
   output logic [NUM_CH-1:0] win_oh,
   output logic [IDX_W-1:0]  win_idx
);
   int   scan_start;
   int   scan_idx;
   logic found;

   always_comb begin
      win_oh     = '0;
      win_idx    = '0;
      found      = 1'b0;
      scan_idx   = 0;
      scan_start = mode ? (int'(last_grant) + 1) : 0;
      if (scan_start >= NUM_CH) begin
         scan_start = 0;
      end
      for (int off = 0; off < NUM_CH; off++) begin
         scan_idx = scan_start + off;
         if (scan_idx >= NUM_CH) begin
            scan_idx = scan_idx - NUM_CH;
         end
         if (!found && req[scan_idx]) begin
            found            = 1'b1;
            win_oh[scan_idx] = 1'b1;
            win_idx          = IDX_W'(scan_idx);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-way arbiter onto the single-port KANADE32 RAM; done pulses WAIT_CYCLES edges after the grant edge.
// Losers simply keep req high (no credits); requests are ignored while an access is in flight.
module mem_port_arbiter
   import kanade_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2,
   parameter int PRIO_MODE   = PRIO_FIXED
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int               IDX_W    = idx_w(NUM_CH);
   localparam int               CNT_W    = cnt_w(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);
   localparam logic             RR_MODE  = (PRIO_MODE == PRIO_RR);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-3:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ram_wren_q, ram_wren_d;
   logic [NUM_CH-1:0] gnt_q, gnt_d;
   logic [NUM_CH-1:0] done_q, done_d;

   logic [NUM_CH-1:0] win_oh;
   logic [IDX_W-1:0]  win_idx;
   logic              sel_we;
   logic [ADDR_W-3:0] sel_waddr;
   logic [DATA_W-1:0] sel_wdata;

   mem_arb_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req        (bus.req),
      .last_grant (last_q),
      .mode       (RR_MODE),
      .win_oh     (win_oh),
      .win_idx    (win_idx)
   );

   // One-hot mux of the winner's request fields; byte-offset bits never reach the RAM.
   always_comb begin
      sel_waddr = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_oh[i]) begin
            sel_waddr = bus.addr[i*ADDR_W+2 +: ADDR_W-2];
            sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign sel_we = |(bus.we & win_oh);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      we_d        = we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      rdata_d     = rdata_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      ram_wren_d  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|bus.req) begin
               state_d     = ARB_BUSY;
               cnt_d       = CNT_LOAD;
               we_d        = sel_we;
               ram_addr_d  = sel_waddr;
               ram_wdata_d = sel_wdata;
               gnt_d       = win_oh;
               ram_wren_d  = sel_we;
               if (RR_MODE) begin
                  last_d = win_idx;
               end
            end
         end
         ARB_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // The done cycle is IDLE, so a held req re-arbitrates on the next edge.
               done_d  = gnt_q;
               gnt_d   = '0;
               state_d = ARB_IDLE;
               if (!we_q) begin
                  rdata_d = bus.ram_q;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         cnt_q       <= '0;
         last_q      <= LAST_RST;
         we_q        <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rdata_q     <= '0;
         ram_wren_q  <= 1'b0;
         gnt_q       <= '0;
         done_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         we_q        <= we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rdata_q     <= rdata_d;
         ram_wren_q  <= ram_wren_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.rdata     = rdata_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.ram_wren  = ram_wren_q;

endmodule
